// File: rtl/blackjack_pkg.sv
// Shared constants and state encoding for the blackjack game blocks.
// The deck is indexed 0..51 as suit*13 + (rank-1).
package blackjack_pkg;

  localparam int          DECK_SIZE  = 52;
  localparam int          RANKS      = 13;
  localparam logic [7:0]  ACE_VALUE  = 8'd11;
  localparam logic [7:0]  FACE_VALUE = 8'd10;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PROBE = 1'b1
  } dealer_state_t;

endpackage

// File: rtl/card_decode.sv
// Combinational card decoder: deck index -> suit, rank and blackjack point value.
// Shared with the game controller's display path.
module card_decode
  import blackjack_pkg::*;
(
  input  logic [5:0] idx,
  output logic [1:0] suit,
  output logic [3:0] rank,
  output logic [7:0] value
);

  localparam logic [5:0] R1 = 6'(RANKS);
  localparam logic [5:0] R2 = 6'(2 * RANKS);
  localparam logic [5:0] R3 = 6'(3 * RANKS);

  logic [5:0] base;

  // Comparator chain instead of a divide-by-13.
  always_comb begin
    suit = 2'd0;
    base = 6'd0;
    if (idx >= R3) begin
      suit = 2'd3;
      base = R3;
    end else if (idx >= R2) begin
      suit = 2'd2;
      base = R2;
    end else if (idx >= R1) begin
      suit = 2'd1;
      base = R1;
    end
    rank = 4'(idx - base) + 4'd1;
    if (rank == 4'd1) begin
      value = ACE_VALUE;
    end else if (rank >= 4'd11) begin
      value = FACE_VALUE;
    end else begin
      value = {4'd0, rank};
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Single-deck card source: deals one undealt card per request, picked by a
// free-running LFSR and linear probing over the used-card mask.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       shuffle,
  output logic       busy,
  output logic       card_valid,
  output logic [5:0] card_index,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [7:0] card_value,
  output logic [5:0] dealt_count,
  output logic       deck_empty,
  output logic       deal_err
);

  localparam logic [5:0] DECK_N    = 6'(DECK_SIZE);
  localparam logic [5:0] DECK_LAST = 6'(DECK_SIZE - 1);

  dealer_state_t state, state_nxt;

  logic [15:0]          lfsr;
  logic [5:0]           cand;
  logic [5:0]           idx;
  logic [DECK_SIZE-1:0] used;

  logic load_idx, step_idx, commit, clear, err;

  logic [1:0] dec_suit;
  logic [3:0] dec_rank;
  logic [7:0] dec_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // Fold 52..63 back into the deck range; the slight bias is acceptable.
  assign cand = (lfsr[5:0] >= DECK_N) ? (lfsr[5:0] - DECK_N) : lfsr[5:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_idx  = 1'b0;
    step_idx  = 1'b0;
    commit    = 1'b0;
    clear     = 1'b0;
    err       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (shuffle) begin
          clear = 1'b1;
        end else if (req) begin
          if (deck_empty) begin
            err = 1'b1;
          end else begin
            load_idx  = 1'b1;
            state_nxt = ST_PROBE;
          end
        end
      end
      ST_PROBE: begin
        if (shuffle) begin
          clear     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!used[idx]) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          step_idx = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  card_decode u_decode (
    .idx   (idx),
    .suit  (dec_suit),
    .rank  (dec_rank),
    .value (dec_value)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= 6'd0;
      used        <= '0;
      dealt_count <= 6'd0;
      card_valid  <= 1'b0;
      deal_err    <= 1'b0;
      card_index  <= 6'd0;
      card_rank   <= 4'd0;
      card_suit   <= 2'd0;
      card_value  <= 8'd0;
    end else begin
      card_valid <= commit;
      deal_err   <= err;
      if (load_idx) begin
        idx <= cand;
      end else if (step_idx) begin
        idx <= (idx == DECK_LAST) ? 6'd0 : idx + 6'd1;
      end
      if (clear) begin
        used        <= '0;
        dealt_count <= 6'd0;
      end else if (commit) begin
        used[idx]   <= 1'b1;
        dealt_count <= dealt_count + 6'd1;
        card_index  <= idx;
        card_rank   <= dec_rank;
        card_suit   <= dec_suit;
        card_value  <= dec_value;
      end
    end
  end

  assign busy       = (state == ST_PROBE);
  assign deck_empty = (dealt_count == DECK_N);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer against a deck-level reference model.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       shuffle = 1'b0;
  logic       busy, card_valid, deck_empty, deal_err;
  logic [5:0] card_index, dealt_count;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [7:0] card_value;

  card_dealer #(.SEED(16'hACE1)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .shuffle     (shuffle),
    .busy        (busy),
    .card_valid  (card_valid),
    .card_index  (card_index),
    .card_rank   (card_rank),
    .card_suit   (card_suit),
    .card_value  (card_value),
    .dealt_count (dealt_count),
    .deck_empty  (deck_empty),
    .deal_err    (deal_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: LFSR sequence, set of dealt cards and count.
  logic [15:0] ref_lfsr;
  bit          ref_used[52];
  int          ref_count = 0;
  int          last_idx = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) ref_lfsr <= 16'hACE1;
    else      ref_lfsr <= lfsr_next(ref_lfsr);
  end

  function automatic int points(input int c);
    int r;
    r = c % 13 + 1;
    if (r == 1) return 11;
    if (r >= 11) return 10;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 52; i++) ref_used[i] = 1'b0;
    ref_count = 0;
  endtask

  // Called at a falling edge with the deck not empty; returns at a falling edge
  // inside the card_valid cycle (or after the cycle budget expired).
  task automatic do_deal(input bit extra_req);
    int  cand, c, k, n;
    bit  got;
    cand = int'(ref_lfsr[5:0]);
    if (cand >= 52) cand -= 52;
    c = cand;
    k = 0;
    while (ref_used[c] && k <= 52) begin
      c = (c == 51) ? 0 : c + 1;
      k++;
    end
    req = 1'b1;
    @(posedge clk); #1;
    check("busy_after_req", busy, 1);
    @(negedge clk);
    req = extra_req;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (card_valid) got = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    check("valid_seen", got, 1);
    check("latency", n, k + 1);
    check("latency_max", (n <= 53), 1);
    check("card_index", card_index, c);
    check("card_rank", card_rank, c % 13 + 1);
    check("card_suit", card_suit, c / 13);
    check("card_value", card_value, points(c));
    check("dealt_count", dealt_count, ref_count + 1);
    check("deck_empty", deck_empty, (ref_count + 1 == 52));
    ref_used[c] = 1'b1;
    ref_count++;
    last_idx = c;
    if (extra_req) begin
      repeat (4) begin
        @(negedge clk);
        check("no_extra_valid", card_valid, 0);
        check("idle_after_deal", busy, 0);
      end
    end
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  initial begin
    bit seen[52];
    int sum, unseen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", card_valid, 0);
    check("rst_index", card_index, 0);
    check("rst_rank", card_rank, 0);
    check("rst_suit", card_suit, 0);
    check("rst_value", card_value, 0);
    check("rst_count", dealt_count, 0);
    check("rst_empty", deck_empty, 0);
    check("rst_err", deal_err, 0);
    model_clear();

    // First deal straight out of reset
    rst = 1'b1;
    do_deal(1'b0);
    check("first_index", card_index, 33);
    check("first_suit", card_suit, 2);
    check("first_rank", card_rank, 8);
    check("first_value", card_value, 8);
    check("first_count", dealt_count, 1);

    // Exhaust the deck
    for (int i = 0; i < 52; i++) seen[i] = 1'b0;
    seen[card_index] = 1'b1;
    sum = int'(card_value);
    unseen = -1;
    for (int i = 1; i < 52; i++) begin
      if (i == 51) for (int j = 0; j < 52; j++) if (!seen[j]) unseen = j;
      if ($urandom_range(0, 4) == 0) gap();
      do_deal($urandom_range(0, 3) == 0);
      check("unique_index", seen[card_index], 0);
      seen[card_index] = 1'b1;
      sum += int'(card_value);
    end
    check("last_is_unseen", card_index, unseen);
    check("full_deck_empty", deck_empty, 1);
    check("value_sum", sum, 380);

    // Request on an empty deck
    @(negedge clk);
    req = 1'b1;
    @(posedge clk); #1;
    check("empty_err", deal_err, 1);
    check("empty_no_valid", card_valid, 0);
    check("empty_not_busy", busy, 0);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    check("err_one_cycle", deal_err, 0);
    check("empty_no_valid2", card_valid, 0);
    check("empty_count", dealt_count, 52);
    @(negedge clk);

    // Shuffle, deal 51, then shuffle in the middle of a probe
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    model_clear();
    check("shuf_count", dealt_count, 0);
    check("shuf_empty", deck_empty, 0);
    for (int i = 0; i < 51; i++) begin
      gap();
      do_deal($urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    req = 1'b1;
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    @(negedge clk);
    req = 1'b0;
    shuffle = 1'b1;
    @(posedge clk); #1;
    check("mid_no_valid", card_valid, 0);
    check("mid_count", dealt_count, 0);
    check("mid_empty", deck_empty, 0);
    check("mid_idle", busy, 0);
    @(negedge clk);
    shuffle = 1'b0;
    model_clear();
    repeat (5) begin
      @(negedge clk);
      check("mid_quiet", card_valid, 0);
    end
    do_deal(1'b0);

    // req and shuffle together in IDLE
    gap();
    do_deal(1'b0);
    gap();
    do_deal(1'b1);
    @(negedge clk);
    req = 1'b1;
    shuffle = 1'b1;
    @(posedge clk); #1;
    check("both_not_busy", busy, 0);
    check("both_count", dealt_count, 0);
    @(negedge clk);
    req = 1'b0;
    shuffle = 1'b0;
    model_clear();
    repeat (5) begin
      @(negedge clk);
      check("both_quiet", card_valid, 0);
    end
    do_deal(1'b0);

    // Reset in the middle of a probe
    @(negedge clk);
    req = 1'b1;
    @(posedge clk); #1;
    check("rp_busy", busy, 1);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    #1;
    check("rp_idle", busy, 0);
    check("rp_count", dealt_count, 0);
    check("rp_index", card_index, 0);
    check("rp_valid", card_valid, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    do_deal(1'b0);
    check("rp_first_index", card_index, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Deck source for the blackjack game controller. It holds a single 52-card deck and deals one undealt card per request, chosen pseudo-randomly by a free-running LFSR with collision probing, so no card repeats until a reshuffle. Each dealt card is returned with its rank, suit and 8-bit blackjack point value, which the game FSM accumulates into its hand totals.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value. Must be non-zero.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `req`, input, 1: single-cycle deal request. Sampled only in IDLE.
- `shuffle`, input, 1: single-cycle reshuffle. Returns every card to the deck.
- `busy`, output, 1: high while a request is being resolved (state PROBE).
- `card_valid`, output, 1: one-cycle pulse; the card outputs are valid this cycle.
- `card_index`, output, 6: dealt card, 0..51.
- `card_rank`, output, 4: 1 (ace) .. 13 (king).
- `card_suit`, output, 2: 0..3.
- `card_value`, output, 8: point value. Ace = 11, ranks 11-13 = 10, otherwise equal to the rank.
- `dealt_count`, output, 6: number of cards dealt since the last shuffle or reset, 0..52.
- `deck_empty`, output, 1: high when `dealt_count == 52`.
- `deal_err`, output, 1: one-cycle pulse when `req` is accepted while the deck is empty.

## Operation
- **LFSR:** 16-bit Galois LFSR, tap mask 16'hB400. It loads `SEED` on reset, advances every cycle unconditionally, and never reaches zero.
- **Used mask:** 52-bit register, one bit per card. It is cleared by reset and by `shuffle`.
- **Candidate selection:** `cand = lfsr[5:0]`; if `cand >= 52`, use `cand - 52` instead. The modulo bias is accepted.
- **States:** IDLE and PROBE.
- **IDLE:**
  - `shuffle` clears the mask and `dealt_count`, then stays in IDLE.
  - Otherwise, `req` with `deck_empty` set pulses `deal_err` next cycle and stays in IDLE.
  - Otherwise, `req` loads `idx <= cand` and moves to PROBE.
- **PROBE**, one slot per cycle:
  - `shuffle` has priority: clear the mask and count, go to IDLE, no `card_valid`.
  - Else if `used[idx] == 0`: set `used[idx]`, increment `dealt_count`, register the card outputs from `idx`, pulse `card_valid` next cycle, go to IDLE.
  - Else: `idx <= (idx == 51) ? 0 : idx + 1` and stay in PROBE.
- Because the deck was not empty on entry, PROBE always ends within 52 cycles.
- Decoding from `idx`: suit = `idx / 13`, rank = `idx % 13 + 1`. Use a comparator chain, not a divider.
- `req` while `busy` is ignored, not queued.
- `req` during the `card_valid` cycle (state is already IDLE) is accepted.
- `req` and `shuffle` in the same IDLE cycle: shuffle wins and the request is dropped.

## Timing
- Reset values: state IDLE, every output 0 (including `deck_empty` and `dealt_count`), LFSR = `SEED`.
- Latency: `req` is sampled at edge N. With k occupied slots probed, `card_valid` is high in the cycle after edge N+1+k. Minimum is 2 cycles from request to valid; maximum is 53.
- Card outputs hold their values until the next deal. Only `card_valid` pulses.
- `dealt_count` and `deck_empty` update on the same edge that raises `card_valid`.
- Reset asserted mid-PROBE aborts immediately. No partial state survives.

## Structure
- Shared package `blackjack_pkg`:
  - constants `DECK_SIZE = 52`, `RANKS = 13`, `ACE_VALUE = 8'd11`, `FACE_VALUE = 8'd10`, `LFSR_TAPS = 16'hB400`;
  - state encoding for card_dealer.
- One sub-module, `card_decode`: purely combinational, maps `idx[5:0]` to `{suit, rank, value}`. It is reused by the game controller for display.
- Expected RTL size: about 150-250 lines.

## Test plan
- **Reset / first deal:** release `rst`, assert `req` at the first edge. Expect LFSR = 16'hACE1 and `cand = 33`, so `card_valid` two cycles later with index 33, suit 2, rank 8, value 8, `dealt_count` 1.
- **Exhaust deck:** issue 52 back-to-back requests.
  - All 52 `card_index` values are unique.
  - Every latency is ≤ 53 cycles.
  - `deck_empty` rises with the 52nd `card_valid`.
  - The 52nd card equals the single index never seen before.
- **Empty request:** `req` with the deck empty → `deal_err` for one cycle, no `card_valid`, `dealt_count` stays 52.
- **Value map:** across a full deck, every rank-1 card has value 11, ranks 11-13 have value 10, and the remaining values equal their rank. The sum of all values is 380.
- **Shuffle mid-probe:** deal 51 cards, `req`, then `shuffle` on the next cycle while `busy` → no `card_valid`, `dealt_count` 0, `deck_empty` 0. The next `req` deals normally.
- **Simultaneous inputs / ignored request:**
  - `req` and `shuffle` in the same IDLE cycle → shuffle applied, no deal.
  - `req` while `busy` → no extra `card_valid`.
